// File: rtl/fmc_i2c_init_sequencer.sv
// fmc_i2c_init_sequencer: table-driven I2C register-write sequencer for FMC424 bring-up.
// On start it walks NUM_ENTRIES {addr, reg, data} table entries. Each entry is sent as
// three byte commands to the I2C byte engine: START+addr, reg, data+STOP.
// Build option FMC_I2C_RETRY_EN: when defined, a NACKed entry is retried up to MAX_RETRY
// times, with BACKOFF_CYC idle cycles before each retry. When undefined, the first NACK
// aborts the run.
module fmc_i2c_init_sequencer #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [22:0]      tbl_entry,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_start,
    output logic             cmd_stop,
    output logic [7:0]       cmd_data,
    input  logic             rsp_valid,
    input  logic             rsp_nack
);

    localparam int unsigned ENTRY_W = 23;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    // Reject configurations that cannot work
    if (NUM_ENTRIES < 1 || NUM_ENTRIES > (1 << IDX_W) || BACKOFF_CYC < 1 || MAX_RETRY > 1024) begin : g_bad_cfg
        $error("fmc_i2c_init_sequencer: illegal parameter set");
    end

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SEND_ADDR,
        WAIT_ADDR,
        SEND_REG,
        WAIT_REG,
        SEND_DATA,
        WAIT_DATA,
`ifdef FMC_I2C_RETRY_EN
        BACKOFF,
`endif
        FINISH
    } state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   entry_reg;

`ifdef FMC_I2C_RETRY_EN
    localparam int unsigned RETRY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned BO_W    = ($clog2(BACKOFF_CYC + 1) > 0) ? $clog2(BACKOFF_CYC + 1) : 1;

    logic [RETRY_W-1:0]   retry_cnt;
    logic [BO_W-1:0]      backoff_cnt;
`endif

    // Sequencer FSM; every command field is set on the edge that enters its SEND state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
            tbl_idx   <= '0;
            cmd_valid <= 1'b0;
            cmd_start <= 1'b0;
            cmd_stop  <= 1'b0;
            cmd_data  <= '0;
            entry_reg <= '0;
`ifdef FMC_I2C_RETRY_EN
            retry_cnt   <= '0;
            backoff_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        err_idx <= '0;
                        tbl_idx <= '0;
                        state   <= LOAD;
                    end
                end

                LOAD: begin
                    entry_reg <= tbl_entry;
`ifdef FMC_I2C_RETRY_EN
                    retry_cnt <= '0;
`endif
                    cmd_valid <= 1'b1;
                    cmd_start <= 1'b1;
                    cmd_stop  <= 1'b0;
                    cmd_data  <= {tbl_entry[22:16], 1'b0};
                    state     <= SEND_ADDR;
                end

                SEND_ADDR, SEND_REG, SEND_DATA: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_start <= 1'b0;
                        cmd_stop  <= 1'b0;
                        cmd_data  <= '0;
                        if (state == SEND_ADDR) begin
                            state <= WAIT_ADDR;
                        end else if (state == SEND_REG) begin
                            state <= WAIT_REG;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end

                WAIT_ADDR, WAIT_REG, WAIT_DATA: begin
                    if (rsp_valid) begin
                        if (rsp_nack) begin
`ifdef FMC_I2C_RETRY_EN
                            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                                backoff_cnt <= '0;
                                state       <= BACKOFF;
                            end else
`endif
                            begin
                                error   <= 1'b1;
                                err_idx <= tbl_idx;
                                done    <= 1'b1;
                                state   <= FINISH;
                            end
                        end else if (state == WAIT_ADDR) begin
                            cmd_valid <= 1'b1;
                            cmd_data  <= entry_reg[15:8];
                            state     <= SEND_REG;
                        end else if (state == WAIT_REG) begin
                            cmd_valid <= 1'b1;
                            cmd_stop  <= 1'b1;
                            cmd_data  <= entry_reg[7:0];
                            state     <= SEND_DATA;
                        end else if (tbl_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            tbl_idx <= tbl_idx + IDX_W'(1);
                            state   <= LOAD;
                        end
                    end
                end

`ifdef FMC_I2C_RETRY_EN
                // Counts 0..BACKOFF_CYC, so the retry address byte appears BACKOFF_CYC+1 edges after the NACK
                BACKOFF: begin
                    if (backoff_cnt == BO_W'(BACKOFF_CYC)) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        cmd_valid <= 1'b1;
                        cmd_start <= 1'b1;
                        cmd_stop  <= 1'b0;
                        cmd_data  <= {entry_reg[22:16], 1'b0};
                        state     <= SEND_ADDR;
                    end else begin
                        backoff_cnt <= backoff_cnt + BO_W'(1);
                    end
                end
`endif

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// Directed bench for fmc_i2c_init_sequencer: single-entry run, backpressured table walk,
// NACK retry/exhaustion (FMC_I2C_RETRY_EN) or immediate abort, misuse and mid-run reset.
module tb_fmc_i2c_init_sequencer;

    localparam int unsigned IDX_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start1, start2;
    logic sel;
    logic cmd_ready_drv, rsp_valid_drv, rsp_nack_drv;

    // dut1: single-entry table, cmd_ready tied high
    logic             busy1, done1, error1, cmd_valid1, cmd_start1, cmd_stop1;
    logic [IDX_W-1:0] err_idx1, tbl_idx1;
    logic [7:0]       cmd_data1;
    logic [22:0]      tbl_entry1;

    // dut2: three-entry table, backpressure and NACK scenarios
    logic             busy2, done2, error2, cmd_valid2, cmd_start2, cmd_stop2;
    logic [IDX_W-1:0] err_idx2, tbl_idx2;
    logic [7:0]       cmd_data2;
    logic [22:0]      tbl_entry2;
    logic             cmd_ready2, rsp_valid1, rsp_valid2;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt1 = 0, done_cnt2 = 0, cmds_cnt2 = 0;

    assign tbl_entry1 = {7'h3E, 8'h02, 8'h01};

    // Bench-side table contents addressed by the sequencer
    always_comb begin
        case (tbl_idx2)
            4'd0:    tbl_entry2 = {7'h3E, 8'h02, 8'h01};
            4'd1:    tbl_entry2 = {7'h21, 8'h10, 8'hA5};
            4'd2:    tbl_entry2 = {7'h50, 8'hFF, 8'h00};
            default: tbl_entry2 = '0;
        endcase
    end

    assign cmd_ready2 = cmd_ready_drv;
    assign rsp_valid1 = rsp_valid_drv & ~sel;
    assign rsp_valid2 = rsp_valid_drv & sel;

    logic       obs_valid, obs_start, obs_stop;
    logic [7:0] obs_data;
    assign obs_valid = sel ? cmd_valid2 : cmd_valid1;
    assign obs_start = sel ? cmd_start2 : cmd_start1;
    assign obs_stop  = sel ? cmd_stop2  : cmd_stop1;
    assign obs_data  = sel ? cmd_data2  : cmd_data1;

    fmc_i2c_init_sequencer #(
        .NUM_ENTRIES(1), .IDX_W(IDX_W), .MAX_RETRY(2), .BACKOFF_CYC(4)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .busy(busy1), .done(done1), .error(error1), .err_idx(err_idx1),
        .tbl_idx(tbl_idx1), .tbl_entry(tbl_entry1),
        .cmd_valid(cmd_valid1), .cmd_ready(1'b1), .cmd_start(cmd_start1),
        .cmd_stop(cmd_stop1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_nack(rsp_nack_drv)
    );

    fmc_i2c_init_sequencer #(
        .NUM_ENTRIES(3), .IDX_W(IDX_W), .MAX_RETRY(2), .BACKOFF_CYC(4)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .busy(busy2), .done(done2), .error(error2), .err_idx(err_idx2),
        .tbl_idx(tbl_idx2), .tbl_entry(tbl_entry2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_start(cmd_start2),
        .cmd_stop(cmd_stop2), .cmd_data(cmd_data2),
        .rsp_valid(rsp_valid2), .rsp_nack(rsp_nack_drv)
    );

    // Event counters for done pulses and accepted dut2 commands
    always @(posedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
        if (cmd_valid2 && cmd_ready2) cmds_cnt2 <= cmds_cnt2 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine model: wait for a command, check it, stall, accept, optionally answer ACK/NACK
    task automatic serve(input logic [7:0] d, input logic s, input logic p,
                         input int stall, input logic nack, input logic respond);
        int t = 0;
        while (!obs_valid && t < 50) begin
            tick();
            t++;
        end
        check_eq("cmd_valid_wait", 32'(obs_valid), 32'd1);
        if (!obs_valid) return;
        check_eq("cmd_data", 32'(obs_data), 32'(d));
        check_eq("cmd_start", 32'(obs_start), 32'(s));
        check_eq("cmd_stop", 32'(obs_stop), 32'(p));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("hold_valid", 32'(obs_valid), 32'd1);
            check_eq("hold_fields", 32'({obs_start, obs_stop, obs_data}), 32'({s, p, d}));
        end
        cmd_ready_drv = 1'b1;
        tick();
        cmd_ready_drv = 1'b0;
        check_eq("valid_drop", 32'(obs_valid), 32'd0);
        check_eq("idle_fields", 32'({obs_start, obs_stop, obs_data}), 32'd0);
        if (respond) begin
            rsp_valid_drv = 1'b1;
            rsp_nack_drv  = nack;
            tick();
            rsp_valid_drv = 1'b0;
            rsp_nack_drv  = 1'b0;
        end
    endtask

    task automatic serve_entry(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d, input int stall);
        serve({a, 1'b0}, 1'b1, 1'b0, stall, 1'b0, 1'b1);
        serve(r, 1'b0, 1'b0, stall, 1'b0, 1'b1);
        serve(d, 1'b0, 1'b1, stall, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state2(input string tag);
        check_eq({tag, "_busy"}, 32'(busy2), 32'd0);
        check_eq({tag, "_done"}, 32'(done2), 32'd0);
        check_eq({tag, "_error"}, 32'(error2), 32'd0);
        check_eq({tag, "_err_idx"}, 32'(err_idx2), 32'd0);
        check_eq({tag, "_tbl_idx"}, 32'(tbl_idx2), 32'd0);
        check_eq({tag, "_cmd_valid"}, 32'(cmd_valid2), 32'd0);
        check_eq({tag, "_cmd_start"}, 32'(cmd_start2), 32'd0);
        check_eq({tag, "_cmd_stop"}, 32'(cmd_stop2), 32'd0);
        check_eq({tag, "_cmd_data"}, 32'(cmd_data2), 32'd0);
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
    endtask

    // Time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_done, base_cmds, k;
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
        cmd_ready_drv = 1'b0; rsp_valid_drv = 1'b0; rsp_nack_drv = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state2("rst");
        check_eq("rst_busy1", 32'(busy1), 32'd0);

        // Single entry, all ACK, ready tied high
        sel = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_eq("t1_busy_after_start", 32'(busy1), 32'd1);
        serve_entry(7'h3E, 8'h02, 8'h01, 0);
        check_eq("t1_done", 32'(done1), 32'd1);
        check_eq("t1_error", 32'(error1), 32'd0);
        check_eq("t1_busy_in_done", 32'(busy1), 32'd1);
        tick();
        check_eq("t1_done_drop", 32'(done1), 32'd0);
        check_eq("t1_busy_drop", 32'(busy1), 32'd0);
        check_eq("t1_done_count", 32'(done_cnt1), 32'd1);

        // Three-entry walk with 5 cycles of backpressure per command
        sel = 1'b1;
        base_done = done_cnt2;
        base_cmds = cmds_cnt2;
        pulse_start2();
        check_eq("t2_busy", 32'(busy2), 32'd1);
        check_eq("t2_idx0", 32'(tbl_idx2), 32'd0);
        serve(8'h7C, 1'b1, 1'b0, 5, 1'b0, 1'b1);
        pulse_start2();  // ignored while busy
        serve(8'h02, 1'b0, 1'b0, 5, 1'b0, 1'b1);
        serve(8'h01, 1'b0, 1'b1, 5, 1'b0, 1'b1);
        check_eq("t2_idx1", 32'(tbl_idx2), 32'd1);
        serve_entry(7'h21, 8'h10, 8'hA5, 5);
        check_eq("t2_idx2", 32'(tbl_idx2), 32'd2);
        serve_entry(7'h50, 8'hFF, 8'h00, 5);
        check_eq("t2_done", 32'(done2), 32'd1);
        check_eq("t2_error", 32'(error2), 32'd0);
        pulse_start2();  // coincident with done: ignored
        check_eq("t2_busy_drop", 32'(busy2), 32'd0);
        tick();
        check_eq("t2_start_on_done_ignored", 32'(busy2), 32'd0);
        check_eq("t2_done_count", 32'(done_cnt2 - base_done), 32'd1);
        check_eq("t2_cmd_count", 32'(cmds_cnt2 - base_cmds), 32'd9);

`ifdef FMC_I2C_RETRY_EN
        // NACK on register byte of entry 0, retried after backoff
        pulse_start2();
        serve(8'h7C, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        serve(8'h02, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        k = 0;
        while (!cmd_valid2 && k < 50) begin
            tick();
            k++;
        end
        check_eq("t3_backoff_edges", 32'(k), 32'd5);
        check_eq("t3_error_during_retry", 32'(error2), 32'd0);
        serve_entry(7'h3E, 8'h02, 8'h01, 0);
        serve_entry(7'h21, 8'h10, 8'hA5, 0);
        serve_entry(7'h50, 8'hFF, 8'h00, 0);
        check_eq("t3_done", 32'(done2), 32'd1);
        check_eq("t3_error", 32'(error2), 32'd0);
        tick();
        tick();

        // Every address byte of entry 1 NACKed: 3 attempts then abort
        base_cmds = cmds_cnt2;
        pulse_start2();
        serve_entry(7'h3E, 8'h02, 8'h01, 0);
        for (int a = 0; a < 3; a++) begin
            serve(8'h42, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        end
        check_eq("t4_error", 32'(error2), 32'd1);
        check_eq("t4_err_idx", 32'(err_idx2), 32'd1);
        check_eq("t4_done", 32'(done2), 32'd1);
        repeat (10) tick();
        check_eq("t4_cmd_count", 32'(cmds_cnt2 - base_cmds), 32'd6);
        check_eq("t4_error_sticky", 32'(error2), 32'd1);
`else
        // First NACK aborts immediately
        base_cmds = cmds_cnt2;
        pulse_start2();
        serve(8'h7C, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("t4_error", 32'(error2), 32'd1);
        check_eq("t4_err_idx", 32'(err_idx2), 32'd0);
        check_eq("t4_done", 32'(done2), 32'd1);
        repeat (10) tick();
        check_eq("t4_cmd_count", 32'(cmds_cnt2 - base_cmds), 32'd1);
        check_eq("t4_error_sticky", 32'(error2), 32'd1);
`endif

        // Start clears error; reset during WAIT_DATA of entry 1
        pulse_start2();
        check_eq("t5_error_cleared", 32'(error2), 32'd0);
        check_eq("t5_idx0", 32'(tbl_idx2), 32'd0);
        serve_entry(7'h3E, 8'h02, 8'h01, 0);
        serve(8'h42, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        serve(8'h10, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        serve(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check_eq("t5_idx_before_reset", 32'(tbl_idx2), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state2("t5_mid_reset");

        // Stray response while idle is ignored, then a clean rerun
        rsp_valid_drv = 1'b1;
        tick();
        rsp_valid_drv = 1'b0;
        check_eq("t6_idle_rsp_ignored", 32'(busy2), 32'd0);
        base_done = done_cnt2;
        pulse_start2();
        check_eq("t6_idx0", 32'(tbl_idx2), 32'd0);
        serve_entry(7'h3E, 8'h02, 8'h01, 0);
        serve_entry(7'h21, 8'h10, 8'hA5, 0);
        serve_entry(7'h50, 8'hFF, 8'h00, 0);
        check_eq("t6_done", 32'(done2), 32'd1);
        check_eq("t6_error", 32'(error2), 32'd0);
        tick();
        tick();
        check_eq("t6_done_count", 32'(done_cnt2 - base_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
